// File: rtl/spsram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM controller.
//   state_e  : controller mode (zero-fill INIT, normal RUN)
//   grant_e  : which request owns the SRAM port this cycle
//   RSP_DEPTH: read response queue depth, which also bounds outstanding reads
package spsram_ctrl_pkg;

  typedef enum logic {INIT, RUN} state_e;

  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} grant_e;

  localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/spsram_ctrl_rspq.sv
// Two-entry response FIFO. Entries shift toward slot 0, so the head is always
// a register and rsp_data stays stable while the consumer stalls.
//   clk, rst_n : clock, async active-low reset (clears occupancy only)
//   push, din  : enqueue one word
//   pop        : dequeue the head (ignored when empty)
//   head       : current head word (meaningful when count != 0)
//   count      : number of valid entries, 0..RSP_DEPTH
module spsram_ctrl_rspq
  import spsram_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;
  logic         push_ok;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    // A push into a full queue is only legal when the head leaves in the same cycle.
    push_ok = push && ((count_q < 2'(RSP_DEPTH)) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = din;
        else                 slot1_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = din;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 2'd0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/spsram_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM with one-cycle
// registered read data. Zero-fills the array after reset, then arbitrates a
// write channel and a read channel onto the port; read data returns through a
// backpressurable response channel guarded by read credits.
//   clk, rst_n                       : clock, async active-low reset
//   init_done                        : array zero-fill complete
//   wr_vld/wr_rdy/wr_addr/wr_data    : write request channel
//   rd_vld/rd_rdy/rd_addr            : read request channel
//   rsp_vld/rsp_rdy/rsp_data         : read response channel
//   sram_en/wen/addr/din, sram_dout  : SRAM port
module spsram_ctrl
  import spsram_ctrl_pkg::*;
#(
  parameter  int W       = 32,
  parameter  int N       = 128,
  parameter  int INIT_EN = 1,
  localparam int AW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_done,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_vld,
  output logic          rd_rdy,
  input  logic [AW-1:0] rd_addr,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [W-1:0]  rsp_data,
  output logic          sram_en,
  output logic          sram_wen,
  output logic [AW-1:0] sram_addr,
  output logic [W-1:0]  sram_din,
  input  logic [W-1:0]  sram_dout
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  // Round-robin pointer: 0 favours the write channel, 1 the read channel.
  logic          rr_q, rr_d;
  grant_e        gnt;
  logic [1:0]    q_count;
  logic          pop;
  logic [2:0]    credit;
  logic          rd_ok;

  assign rsp_vld   = (q_count != 2'd0);
  assign pop       = rsp_vld && rsp_rdy;
  assign init_done = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    gnt        = GNT_NONE;
    wr_rdy     = 1'b0;
    rd_rdy     = 1'b0;
    sram_en    = 1'b0;
    sram_wen   = 1'b0;
    sram_addr  = '0;
    sram_din   = '0;
    // Count the slot freed by a same-cycle pop so streaming reads never stall.
    credit     = {1'b0, q_count} + {2'b0, inflight_q} - {2'b0, pop};
    rd_ok      = (credit < 3'(RSP_DEPTH));

    case (state_q)
      INIT: begin
        sram_en  = 1'b1;
        sram_wen = 1'b1;
        sram_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        wr_rdy = !(rd_vld && rd_ok) || !rr_q;
        rd_rdy = rd_ok && (!wr_vld || rr_q);
        if (wr_vld && wr_rdy)      gnt = GNT_WR;
        else if (rd_vld && rd_rdy) gnt = GNT_RD;
        if (wr_vld && rd_vld && rd_ok) rr_d = !rr_q;
        case (gnt)
          GNT_WR: begin
            sram_en   = 1'b1;
            sram_wen  = 1'b1;
            sram_addr = wr_addr;
            sram_din  = wr_data;
          end
          GNT_RD: begin
            sram_en   = 1'b1;
            sram_addr = rd_addr;
          end
          default: ;
        endcase
      end
      default: state_d = RUN;
    endcase

    inflight_d = (gnt == GNT_RD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (INIT_EN != 0) ? INIT : RUN;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
    end
  end

  // SRAM data for the read issued last cycle is captured at the end of this one.
  spsram_ctrl_rspq #(.W(W)) u_rspq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (sram_dout),
    .pop   (pop),
    .head  (rsp_data),
    .count (q_count)
  );

  a_credit : assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, q_count} + {2'b0, inflight_q}) <= 3'(RSP_DEPTH));

endmodule

// File: tb/tb_spsram_ctrl.sv
module tb_spsram_ctrl;

  localparam int W  = 32;
  localparam int N  = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          wr_vld, wr_rdy;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_vld, rd_rdy;
  logic [AW-1:0] rd_addr;
  logic          rsp_vld, rsp_rdy;
  logic [W-1:0]  rsp_data;
  logic          sram_en, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_din, sram_dout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spsram_ctrl #(.W(W), .N(N), .INIT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_addr(rd_addr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Single-port SRAM model with one-cycle registered read data.
  logic [W-1:0] sram_mem [0:N-1];
  initial for (int i = 0; i < N; i++) sram_mem[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_wen) sram_mem[sram_addr] <= sram_din;
      else          sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    int           due;
  } ent_t;

  ent_t         m_q[$];
  logic [W-1:0] ref_mem [0:N-1];
  bit           m_run;
  int           m_init_idx;
  bit           m_prefer_wr;
  bit           m_exp_vld, m_pop, m_rd_ok, m_wr_e, m_rd_e;
  int           m_g;  // 0 none, 1 write, 2 read
  ent_t         m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_wr_rdy", wr_rdy, 0);
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_init_done", init_done, 0);
      m_q.delete();
      m_run       = 0;
      m_init_idx  = 0;
      m_prefer_wr = 1;
    end else if (!m_run) begin
      chk("init_en", sram_en, 1);
      chk("init_wen", sram_wen, 1);
      chk("init_addr", sram_addr, m_init_idx);
      chk("init_din", sram_din, 0);
      chk("init_wr_rdy", wr_rdy, 0);
      chk("init_rd_rdy", rd_rdy, 0);
      chk("init_done_low", init_done, 0);
      chk("init_rsp_vld", rsp_vld, 0);
      m_init_idx++;
      if (m_init_idx == N) begin
        m_run = 1;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
      end
    end else begin
      chk("run_init_done", init_done, 1);
      m_exp_vld = (m_q.size() > 0) && (m_q[0].due <= cyc);
      chk("rsp_vld", rsp_vld, m_exp_vld);
      if (m_exp_vld) chk("rsp_data", rsp_data, m_q[0].data);
      m_pop   = m_exp_vld && rsp_rdy;
      // Accepted-but-unconsumed reads may never exceed the two queue slots.
      m_rd_ok = (m_q.size() - int'(m_pop)) < 2;
      m_wr_e  = wr_vld;
      m_rd_e  = rd_vld && m_rd_ok;
      if (m_wr_e && m_rd_e) begin
        m_g = m_prefer_wr ? 1 : 2;
        m_prefer_wr = !m_prefer_wr;
      end else if (m_wr_e) m_g = 1;
      else if (m_rd_e)     m_g = 2;
      else                 m_g = 0;
      if (!m_rd_ok) chk("rd_rdy_no_credit", rd_rdy, 0);
      chk("wr_handshake", wr_vld && wr_rdy, m_g == 1);
      chk("rd_handshake", rd_vld && rd_rdy, m_g == 2);
      chk("sram_en", sram_en, m_g != 0);
      chk("sram_wen", sram_wen, m_g == 1);
      if (m_g == 1) begin
        chk("sram_addr_wr", sram_addr, wr_addr);
        chk("sram_din_wr", sram_din, wr_data);
      end else if (m_g == 2) begin
        chk("sram_addr_rd", sram_addr, rd_addr);
      end else begin
        chk("sram_addr_idle", sram_addr, 0);
        chk("sram_din_idle", sram_din, 0);
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_g == 1) ref_mem[wr_addr] = wr_data;
      if (m_g == 2) begin
        m_e.data = ref_mem[rd_addr];
        m_e.due  = cyc + 2;
        m_q.push_back(m_e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int k = 0;
    while (init_done !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk({name, "_done"}, init_done, 1);
    chk({name, "_cycles"}, k, N);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    int k = 0;
    wr_vld = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    while (!wr_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("wr_accept", wr_rdy, 1);
    step();
    wr_vld = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int k = 0;
    rd_vld = 1; rd_addr = a;
    @(negedge clk);
    while (!rd_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rd_accept", rd_rdy, 1);
    step();
    rd_vld = 0;
  endtask

  // Read with an empty queue and rsp_rdy=1: response 2 cycles after accept.
  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] d);
    do_read(a);
    @(negedge clk);
    chk({name, "_vld_early"}, rsp_vld, 0);
    step();
    @(negedge clk);
    chk({name, "_vld"}, rsp_vld, 1);
    chk({name, "_data"}, rsp_data, d);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; wr_vld = 0; wr_addr = '0; wr_data = '0;
    rd_vld = 0; rd_addr = '0; rsp_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    // Zero-fill, then a filled location reads back as zero.
    wait_init("fill");
    read_check("fill_rd5", 7'd5, 32'h0);

    // Write followed immediately by a read of the same address.
    do_write(7'd3, 32'hDEADBEEF);
    read_check("wr_rd3", 7'd3, 32'hDEADBEEF);

    // Backpressure: only two reads fit while the consumer stalls.
    do_write(7'd1, 32'h11111111);
    do_write(7'd2, 32'h22222222);
    do_write(7'd3, 32'h33333333);
    rsp_rdy = 0;
    do_read(7'd1);
    do_read(7'd2);
    rd_vld = 1; rd_addr = 7'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rd_rdy_low", rd_rdy, 0);
      chk("bp_hold_vld", rsp_vld, 1);
      chk("bp_hold_data", rsp_data, 32'h11111111);
      step();
    end
    rsp_rdy = 1;
    @(negedge clk);
    chk("bp_rd_rdy_on_pop", rd_rdy, 1);
    chk("bp_rsp1", rsp_data, 32'h11111111);
    step();
    rd_vld = 0;
    @(negedge clk);
    chk("bp_rsp2", rsp_data, 32'h22222222);
    step();
    @(negedge clk);
    chk("bp_rsp3_vld", rsp_vld, 1);
    chk("bp_rsp3", rsp_data, 32'h33333333);
    step();
    @(negedge clk);
    chk("bp_drained", rsp_vld, 0);
    step();

    // Contention: both channels always requesting alternate W,R,W,R...
    wr_vld = 1; wr_addr = 7'd10; rd_vld = 1; rd_addr = 7'd10;
    for (int i = 0; i < 8; i++) begin
      wr_data = 32'h1000 + i;
      @(negedge clk);
      chk("cont_en", sram_en, 1);
      chk("cont_wen", sram_wen, (i % 2) == 0);
      step();
    end
    wr_vld = 0; rd_vld = 0;
    repeat (4) step();

    // Streaming: 16 back-to-back reads.
    rd_vld = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 7'(i);
      @(negedge clk);
      chk("stream_rd_rdy", rd_rdy, 1);
      if (i >= 2) chk("stream_vld", rsp_vld, 1);
      step();
    end
    rd_vld = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stream_tail_vld", rsp_vld, 1);
      step();
    end
    @(negedge clk);
    chk("stream_end_vld", rsp_vld, 0);
    step();

    // Asynchronous reset with one response queued and one read in flight.
    rsp_rdy = 0;
    do_read(7'd20);
    do_read(7'd21);
    wr_vld = 1; rd_vld = 1;
    rst_n = 0;
    #1;
    chk("areset_rsp_vld", rsp_vld, 0);
    chk("areset_wr_rdy", wr_rdy, 0);
    chk("areset_rd_rdy", rd_rdy, 0);
    chk("areset_init_done", init_done, 0);
    wr_vld = 0; rd_vld = 0;
    step();
    step();
    rst_n = 1;
    @(negedge clk);
    chk("refill_en", sram_en, 1);
    chk("refill_addr0", sram_addr, 0);
    rsp_rdy = 1;
    wait_init("refill");
    read_check("refill_rd3", 7'd3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
